// File: rtl/as_cgu_multi_pkg.sv
// Shared types and reset defaults for the multi-channel clock generation unit.
package as_cgu_multi_pkg;

    localparam int CGU_CNT_W = 8;
    typedef logic [CGU_CNT_W-1:0] cgu_div_t;

    localparam cgu_div_t clk_core_div = 8'd4;
    localparam cgu_div_t clk_qspi_div = 8'd6;
    localparam cgu_div_t clk_bus1_div = 8'd5;
    localparam cgu_div_t clk_bus2_div = 8'd8;

    localparam int CGU_NUM_CH_DEFAULT = 4;

    // Element [k] is the reset divisor of channel k.
    localparam cgu_div_t [CGU_NUM_CH_DEFAULT-1:0] CGU_DIV_RST_DEFAULT =
        {clk_bus2_div, clk_bus1_div, clk_qspi_div, clk_core_div};

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } cgu_chan_state_e;

endpackage

// File: rtl/as_cgu_chan.sv
// One divided-clock channel: counter, active/shadow divisor, enable drain and sync restart.
module as_cgu_chan
    import as_cgu_multi_pkg::*;
#(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] DIV_RST = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             pend_o,
    output cgu_chan_state_e  state_o
);

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

    localparam logic [CNT_W-1:0] DIV_RST_C = clamp_div(DIV_RST);

    cgu_chan_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, div_act_q, div_shd_q;
    logic [CNT_W-1:0] cnt_inc, half;
    logic             pend_q, clk_q, tick_q;
    logic             run, boundary, restart, apply_shd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A running channel only returns to idle at the end of a full period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CH_IDLE: if (en_i) state_d = CH_RUN;
            CH_RUN:  if (boundary && !en_i) state_d = CH_IDLE;
            default: state_d = CH_IDLE;
        endcase
    end

    // Sync only restarts channels whose enable is still requested.
    always_comb begin
        run       = (state_q == CH_RUN);
        boundary  = run && (cnt_q == div_act_q - CNT_W'(1));
        restart   = en_i && (!run || boundary || sync_i);
        apply_shd = pend_q && (!run || boundary || (sync_i && en_i));
        cnt_inc   = cnt_q + CNT_W'(1);
        half      = div_act_q >> 1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            pend_q    <= 1'b0;
            div_act_q <= DIV_RST_C;
            div_shd_q <= DIV_RST_C;
        end else begin
            tick_q <= restart;
            if (restart) begin
                cnt_q <= '0;
                clk_q <= 1'b1;
            end else if (run && !boundary) begin
                cnt_q <= cnt_inc;
                clk_q <= (cnt_inc < half);
            end else begin
                cnt_q <= '0;
                clk_q <= 1'b0;
            end
            if (apply_shd) begin
                div_act_q <= div_shd_q;
            end
            // A write coinciding with an apply lands in the shadow and stays pending.
            if (wr_en_i) begin
                div_shd_q <= clamp_div(wr_div_i);
                pend_q    <= 1'b1;
            end else if (apply_shd) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign clk_o   = clk_q;
    assign tick_o  = tick_q;
    assign pend_o  = pend_q;
    assign state_o = state_q;

endmodule

// File: rtl/as_cgu_multi.sv
// N-channel clock generation unit: one as_cgu_chan per output plus divisor-write decode.
module as_cgu_multi
    import as_cgu_multi_pkg::*;
#(
    parameter int                     NUM_CH  = 4,
    parameter int                     CNT_W   = 8,
    parameter cgu_div_t [NUM_CH-1:0]  DIV_RST = CGU_DIV_RST_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic                    sync_i,
    input  logic                    wr_en_i,
    input  logic [$clog2(NUM_CH):0] wr_ch_i,
    input  logic [CNT_W-1:0]        wr_div_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       pend_o,
    output logic [NUM_CH-1:0]       run_o
);

    localparam int CH_W = $clog2(NUM_CH) + 1;

    // Out-of-range channel indices match no instance and are dropped.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        cgu_chan_state_e state;
        logic            wr_sel;

        assign wr_sel = wr_en_i && (wr_ch_i == CH_W'(k));

        as_cgu_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (CNT_W'(DIV_RST[k]))
        ) u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (en_i[k]),
            .sync_i   (sync_i),
            .wr_en_i  (wr_sel),
            .wr_div_i (wr_div_i),
            .clk_o    (clk_o[k]),
            .tick_o   (tick_o[k]),
            .pend_o   (pend_o[k]),
            .state_o  (state)
        );

        assign run_o[k] = (state == CH_RUN);
    end

endmodule

// File: tb/tb_as_cgu_multi.sv
// Directed bench for as_cgu_multi with default divisors {4,6,5,8}; patterns are MSB-first in time.
module tb_as_cgu_multi;

    logic       clk_i;
    logic       rst_ni;
    logic [3:0] en_i;
    logic       sync_i;
    logic       wr_en_i;
    logic [2:0] wr_ch_i;
    logic [7:0] wr_div_i;
    logic [3:0] clk_o;
    logic [3:0] tick_o;
    logic [3:0] pend_o;
    logic [3:0] run_o;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [15:0] cap_clk  [4];
    logic [15:0] cap_tick [4];
    logic [15:0] cap_pend [4];
    logic [15:0] cap_run  [4];

    as_cgu_multi dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (en_i),
        .sync_i   (sync_i),
        .wr_en_i  (wr_en_i),
        .wr_ch_i  (wr_ch_i),
        .wr_div_i (wr_div_i),
        .clk_o    (clk_o),
        .tick_o   (tick_o),
        .pend_o   (pend_o),
        .run_o    (run_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no summary, expected end of sequence");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample_n(input int n);
        for (int k = 0; k < 4; k++) begin
            cap_clk[k]  = '0;
            cap_tick[k] = '0;
            cap_pend[k] = '0;
            cap_run[k]  = '0;
        end
        repeat (n) begin
            step();
            for (int k = 0; k < 4; k++) begin
                cap_clk[k]  = {cap_clk[k][14:0], clk_o[k]};
                cap_tick[k] = {cap_tick[k][14:0], tick_o[k]};
                cap_pend[k] = {cap_pend[k][14:0], pend_o[k]};
                cap_run[k]  = {cap_run[k][14:0], run_o[k]};
            end
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        en_i     = 4'hf;
        sync_i   = 1'b0;
        wr_en_i  = 1'b0;
        wr_ch_i  = 3'd0;
        wr_div_i = 8'd0;

        repeat (2) step();
        check("rst_clk", clk_o, 4'b0000);
        check("rst_tick", tick_o, 4'b0000);
        check("rst_pend", pend_o, 4'b0000);
        check("rst_run", run_o, 4'b0000);

        // Release between edges; first edge starts every channel high.
        rst_ni = 1'b1;
        sample_n(10);
        check("t1_clk0_d4", cap_clk[0], 10'b1100110011);
        check("t1_clk1_d6", cap_clk[1], 10'b1110001110);
        check("t2_clk2_d5", cap_clk[2], 10'b1100011000);
        check("t1_clk3_d8", cap_clk[3], 10'b1111000011);
        check("t1_tick0", cap_tick[0], 10'b1000100010);
        check("t1_tick1", cap_tick[1], 10'b1000001000);
        check("t2_tick2", cap_tick[2], 10'b1000010000);

        // Phases now mixed: ch0 cnt1, ch1 cnt3, ch2 cnt4, ch3 cnt1.
        sync_i = 1'b1;
        step();
        check("t5_sync_clk", clk_o, 4'b1111);
        check("t5_sync_tick", tick_o, 4'b1111);
        sync_i = 1'b0;
        step();
        check("t5_post_tick", tick_o, 4'b0000);
        check("t5_post_clk", clk_o, 4'b1111);

        // ch1 at cnt2: write D=10.
        step();
        wr_en_i  = 1'b1;
        wr_ch_i  = 3'd1;
        wr_div_i = 8'd10;
        step();
        check("t3_pend_set", pend_o, 4'b0010);
        wr_en_i = 1'b0;
        sample_n(13);
        check("t3_clk1_d10", cap_clk[1], 13'b0011111000001);
        check("t3_pend1", cap_pend[1], 13'b1100000000000);
        check("t3_tick1", cap_tick[1], 13'b0010000000001);

        // ch3 at cnt1 (high phase): drop enable.
        step();
        en_i[3] = 1'b0;
        sample_n(10);
        check("t4_clk3_drain", cap_clk[3], 10'b1100000000);
        check("t4_run3", cap_run[3], 10'b1111110000);
        check("t4_tick3", cap_tick[3], 10'b0000000000);
        en_i[3] = 1'b1;
        step();
        check("t4_reen_clk3", clk_o[3], 1'b1);
        check("t4_reen_tick", tick_o, 4'b1001);

        // ch0 at cnt0: write D=0 (clamps to 2), then an out-of-range write.
        wr_en_i  = 1'b1;
        wr_ch_i  = 3'd0;
        wr_div_i = 8'd0;
        step();
        check("t6_pend_d0", pend_o, 4'b0001);
        check("t6_clk0_old", clk_o[0], 1'b1);
        wr_ch_i  = 3'd7;
        wr_div_i = 8'd3;
        step();
        check("t6_pend_ch7", pend_o, 4'b0001);
        wr_en_i = 1'b0;
        sample_n(5);
        check("t6_clk0_d2", cap_clk[0], 5'b01010);
        check("t6_pend0", cap_pend[0], 5'b10000);

        // Boundary and write on the same channel: old shadow applies, pend stays set.
        step();
        wr_en_i  = 1'b1;
        wr_ch_i  = 3'd0;
        wr_div_i = 8'd4;
        step();
        check("bw_pend_first", pend_o[0], 1'b1);
        check("bw_clk0_low", clk_o[0], 1'b0);
        wr_div_i = 8'd6;
        step();
        check("bw_pend_kept", pend_o[0], 1'b1);
        check("bw_clk0_rise", clk_o[0], 1'b1);
        check("bw_tick0", tick_o[0], 1'b1);
        wr_en_i = 1'b0;
        sample_n(4);
        check("bw_clk0_d4", cap_clk[0], 4'b1001);
        check("bw_pend0", cap_pend[0], 4'b1110);

        // Asynchronous reset mid-period, away from any edge.
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_clk", clk_o, 4'b0000);
        check("ar_tick", tick_o, 4'b0000);
        check("ar_pend", pend_o, 4'b0000);
        check("ar_run", run_o, 4'b0000);
        #2;
        rst_ni = 1'b1;
        sample_n(5);
        check("ar_clk0_default", cap_clk[0], 5'b11001);
        check("ar_clk1_default", cap_clk[1], 5'b11100);
        check("ar_pend0", cap_pend[0], 5'b00000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
